// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Shares the data_mem port between the CPU load/store path and a
//            word-wide DMA/debug requester, one transaction at a time.
// Option   : DATA_MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic [3:0]        cpu_sign_mask,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_clk_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_clk_stall
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic       OWN_CPU       = 1'b0;
  localparam logic       OWN_DMA       = 1'b1;
  localparam logic [3:0] DMA_SIGN_MASK = 4'b0100;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                is_read_q, is_read_d;
  logic                holdoff_q, holdoff_d;
  logic                mem_memread_q, mem_memread_d;
  logic                mem_memwrite_q, mem_memwrite_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic [3:0]          mem_sign_mask_q, mem_sign_mask_d;
  logic [DATA_W-1:0]   cpu_read_data_q, cpu_read_data_d;
  logic                cpu_clk_stall_q, cpu_clk_stall_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic cpu_pend;
  logic dma_pend;
  logic grant_cpu;

  assign cpu_pend = (cpu_memread | cpu_memwrite) & ~holdoff_q;
  // The requester still holds dma_req in its ack cycle; do not re-grant it.
  assign dma_pend = dma_req & ~dma_ack_q;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;
  assign grant_cpu = cpu_pend & (~dma_pend | (rr_q == OWN_CPU));
`else
  assign grant_cpu = cpu_pend;
`endif

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    is_read_d        = is_read_q;
    holdoff_d        = 1'b0;
    mem_memread_d    = 1'b0;
    mem_memwrite_d   = 1'b0;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_sign_mask_d  = mem_sign_mask_q;
    cpu_read_data_d  = cpu_read_data_q;
    cpu_clk_stall_d  = cpu_clk_stall_q;
    dma_ack_d        = 1'b0;
    dma_rdata_d      = dma_rdata_q;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    rr_d             = rr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cpu_clk_stall_d = cpu_pend;
        if (cpu_pend | dma_pend) begin
          state_d = ST_ISSUE;
          if (grant_cpu) begin
            owner_d          = OWN_CPU;
            is_read_d        = cpu_memread;
            mem_memread_d    = cpu_memread;
            mem_memwrite_d   = cpu_memwrite;
            mem_addr_d       = cpu_addr;
            mem_write_data_d = cpu_write_data;
            mem_sign_mask_d  = cpu_sign_mask;
          end else begin
            owner_d          = OWN_DMA;
            is_read_d        = ~dma_we;
            mem_memread_d    = ~dma_we;
            mem_memwrite_d   = dma_we;
            mem_addr_d       = dma_addr;
            mem_write_data_d = dma_wdata;
            mem_sign_mask_d  = DMA_SIGN_MASK;
          end
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
          // Only a contended grant moves the pointer.
          if (cpu_pend & dma_pend) rr_d = grant_cpu ? OWN_DMA : OWN_CPU;
`endif
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (cpu_pend) cpu_clk_stall_d = 1'b1;
      end

      ST_WAIT: begin
        if (cpu_pend) cpu_clk_stall_d = 1'b1;
        if (!mem_clk_stall) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_CPU) begin
            if (is_read_q) cpu_read_data_d = mem_read_data;
            cpu_clk_stall_d = 1'b0;
            holdoff_d       = 1'b1;
          end else begin
            dma_ack_d   = 1'b1;
            dma_rdata_d = mem_read_data;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      owner_q          <= OWN_CPU;
      is_read_q        <= 1'b0;
      holdoff_q        <= 1'b0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      mem_sign_mask_q  <= '0;
      cpu_read_data_q  <= '0;
      cpu_clk_stall_q  <= 1'b0;
      dma_ack_q        <= 1'b0;
      dma_rdata_q      <= '0;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
      rr_q             <= OWN_CPU;
`endif
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      is_read_q        <= is_read_d;
      holdoff_q        <= holdoff_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_sign_mask_q  <= mem_sign_mask_d;
      cpu_read_data_q  <= cpu_read_data_d;
      cpu_clk_stall_q  <= cpu_clk_stall_d;
      dma_ack_q        <= dma_ack_d;
      dma_rdata_q      <= dma_rdata_d;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
      rr_q             <= rr_d;
`endif
    end
  end

  assign cpu_read_data  = cpu_read_data_q;
  assign cpu_clk_stall  = cpu_clk_stall_q;
  assign dma_ack        = dma_ack_q;
  assign dma_rdata      = dma_rdata_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_sign_mask  = mem_sign_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural data_mem, directed timing cases and
// randomized concurrent CPU/DMA traffic checked against a word-array reference.
`default_nettype none

module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_memread = 1'b0, cpu_memwrite = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_write_data = '0;
  logic [3:0]  cpu_sign_mask = '0;
  logic [31:0] cpu_read_data;
  logic        cpu_clk_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        mem_memread, mem_memwrite;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_clk_stall;

  int n_checks = 0, n_fail = 0;
  int exp_pulses = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr),
    .cpu_write_data(cpu_write_data), .cpu_sign_mask(cpu_sign_mask),
    .cpu_read_data(cpu_read_data), .cpu_clk_stall(cpu_clk_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'hA5A5_0001;
    return 32'h3C00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // mask 4'b0100 is a word access, anything else a byte access at addr[1:0]
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (m == 4'b0100) r = wd;
    else r[8*off +: 8] = wd[7:0];
    return r;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] w, input logic [3:0] m,
                                          input logic [1:0] off);
    if (m == 4'b0100) return w;
    return {24'h0, w[8*off +: 8]};
  endfunction

  // data_mem: busy (stall) the cycle after a request pulse, using the live address
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        init_done = 1'b0, mem_busy = 1'b0, op_rd = 1'b0, op_wr = 1'b0;
  logic [31:0] mem_rdata_r = '0;
  assign mem_read_data = mem_rdata_r;
  assign mem_clk_stall = mem_busy;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (mem_busy) begin
      mem_busy <= 1'b0;
      if (op_rd) mem_rdata_r <= rd_word(mem[mem_addr[9:2]], mem_sign_mask, mem_addr[1:0]);
      else if (op_wr)
        mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_write_data, mem_sign_mask, mem_addr[1:0]);
    end else if (mem_memread || mem_memwrite) begin
      mem_busy <= 1'b1;
      op_rd    <= mem_memread;
      op_wr    <= mem_memwrite;
    end
  end

  int   cyc = 0, n_pulses = 0, pulse_viol = 0, hold_viol = 0, gap_viol = 0;
  int   stream_acks = 0, last_fall = 0;
  logic prev_pulse = 1'b0, stall_prev = 1'b0, stream_on = 1'b0;
  logic [3:0] dma_mask_seen = '0;

  always @(negedge clk) begin
    cyc++;
    if (mem_memread || mem_memwrite) begin
      n_pulses++;
      if (prev_pulse) pulse_viol++;
    end
    prev_pulse = mem_memread | mem_memwrite;
    if (stall_prev && !cpu_clk_stall) begin
      last_fall = cyc;
      if (mem_memread) hold_viol++;
    end
    stall_prev = cpu_clk_stall;
    if (stream_on && dma_ack) begin
      stream_acks++;
      if (cyc - last_fall > 5) gap_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a CPU access, returns load data and the number of stalled cycles.
  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] m,
                        output logic [31:0] rdata, output int stall);
    cpu_memread = rd; cpu_memwrite = wr; cpu_addr = addr;
    cpu_write_data = wd; cpu_sign_mask = m;
    exp_pulses++;
    if (wr && !rd) ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wd, m, addr[1:0]);
    stall = 0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (!cpu_clk_stall) break;
      stall++;
    end
    if (stall >= 64) chk("cpu_timeout", 32'(stall), 32'd0);
    rdata = cpu_read_data;
    @(posedge clk); #1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output int lat);
    logic got;
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    exp_pulses++;
    if (we) ref_mem[addr[9:2]] = wd;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      lat++;
      if ((mem_memread || mem_memwrite) && mem_addr == addr) dma_mask_seen = mem_sign_mask;
      if (dma_ack) begin got = 1'b1; break; end
    end
    if (!got) chk("dma_timeout", 32'(lat), 32'd0);
    rdata = dma_rdata;
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  logic [31:0] r_cpu, r_dma, exp_w;
  int          s_cpu, l_dma, nbad;
  logic        cpu_wins;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'h0, cpu_clk_stall}, 32'd0);
    chk("rst_memrd", {31'h0, mem_memread | mem_memwrite}, 32'd0);
    chk("rst_ack", {31'h0, dma_ack}, 32'd0);
    chk("rst_cpu_rdata", cpu_read_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Uncontended CPU load
    cpu_op(1'b1, 1'b0, 32'h4008, 32'h0, 4'b0100, r_cpu, s_cpu);
    chk("cpu_lw_stall", 32'(s_cpu), 32'd3);
    chk("cpu_lw_data", r_cpu, 32'hA5A5_0001);
    chk("cpu_lw_pulses", 32'(n_pulses), 32'd1);

    // DMA write then CPU read-back
    dma_op(1'b1, 32'h4010, 32'hDEAD_BEEF, r_dma, l_dma);
    chk("dma_wr_lat", 32'(l_dma), 32'd4);
    chk("dma_mask", {28'h0, dma_mask_seen}, 32'h4);
    cpu_op(1'b1, 1'b0, 32'h4010, 32'h0, 4'b0100, r_cpu, s_cpu);
    chk("cpu_rb_data", r_cpu, 32'hDEAD_BEEF);
    chk("cpu_rb_stall", 32'(s_cpu), 32'd3);

    // Same-cycle contention, three times
    for (int i = 0; i < 3; i++) begin
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
      cpu_wins = (i != 1);
`else
      cpu_wins = 1'b1;
`endif
      fork
        cpu_op(1'b1, 1'b0, 32'h4008, 32'h0, 4'b0100, r_cpu, s_cpu);
        dma_op(1'b0, 32'h4010, 32'h0, r_dma, l_dma);
      join
      chk("cont_cpu_stall", 32'(s_cpu), cpu_wins ? 32'd3 : 32'd7);
      chk("cont_dma_lat", 32'(l_dma), cpu_wins ? 32'd8 : 32'd4);
      chk("cont_cpu_data", r_cpu, ref_mem[2]);
      chk("cont_dma_data", r_dma, ref_mem[4]);
      @(posedge clk); #1;
    end

    // CPU byte store arriving while DMA is in WAIT
    begin
      int p0;
      p0 = n_pulses;
      fork
        dma_op(1'b1, 32'h4020, 32'h1234_5678, r_dma, l_dma);
        begin
          repeat (2) @(posedge clk);
          #1;
          cpu_op(1'b0, 1'b1, 32'h4001, 32'h0000_007F, 4'b0000, r_cpu, s_cpu);
        end
      join
      chk("sb_dma_lat", 32'(l_dma), 32'd4);
      chk("sb_cpu_stall", 32'(s_cpu), 32'd5);
      chk("sb_pulses", 32'(n_pulses - p0), 32'd2);
      exp_w = merge(init_word(0), 32'h7F, 4'b0000, 2'd1);
      cpu_op(1'b1, 1'b0, 32'h4000, 32'h0, 4'b0100, r_cpu, s_cpu);
      chk("sb_readback", r_cpu, exp_w);
    end

    // CPU load stream with DMA requesting continuously
    last_fall = cyc;
    stream_acks = 0;
    stream_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [31:0] a;
          a = 32'h4000 + 32'($urandom_range(16, 79)) * 4;
          cpu_op(1'b1, 1'b0, a, 32'h0, 4'b0100, r_cpu, s_cpu);
          chk("stream_cpu_data", r_cpu, ref_mem[a[9:2]]);
        end
        stream_on = 1'b0;
      end
      begin
        logic [31:0] rd;
        int lt;
        while (stream_on) begin
          logic [31:0] a;
          a = 32'h4000 + 32'($urandom_range(128, 191)) * 4;
          dma_op(1'b0, a, 32'h0, rd, lt);
          chk("stream_dma_data", rd, ref_mem[a[9:2]]);
        end
      end
    join
    chk("stream_ack_gap", 32'(gap_viol), 32'd0);
    chk("stream_acks_min", {31'h0, stream_acks >= 10}, 32'd1);
    chk("holdoff_no_read", 32'(hold_viol), 32'd0);

    // Reset during WAIT abandons the access
    @(posedge clk); #1;
    cpu_memread = 1'b1; cpu_addr = 32'h4008; cpu_sign_mask = 4'b0100;
    exp_pulses++;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_stall", {31'h0, cpu_clk_stall}, 32'd0);
    chk("arst_mem_rw", {30'h0, mem_memread, mem_memwrite}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_cpu_rdata", cpu_read_data, 32'd0);
    cpu_memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    cpu_op(1'b1, 1'b0, 32'h4008, 32'h0, 4'b0100, r_cpu, s_cpu);
    chk("post_rst_stall", 32'(s_cpu), 32'd3);
    chk("post_rst_data", r_cpu, ref_mem[2]);

    // Randomized concurrent traffic on disjoint regions
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [31:0] a, d;
          int kind;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          kind = $urandom_range(0, 2);
          a = 32'h4000 + 32'($urandom_range(16, 79)) * 4;
          d = $urandom;
          if (kind == 0) begin
            cpu_op(1'b1, 1'b0, a, 32'h0, 4'b0100, r_cpu, s_cpu);
            chk("rnd_cpu_data", r_cpu, ref_mem[a[9:2]]);
          end else if (kind == 1) begin
            cpu_op(1'b0, 1'b1, a, d, 4'b0100, r_cpu, s_cpu);
          end else begin
            a[1:0] = 2'($urandom_range(0, 3));
            cpu_op(1'b0, 1'b1, a, d, 4'b0000, r_cpu, s_cpu);
          end
          chk("rnd_cpu_stall_bound", {31'h0, s_cpu <= 8}, 32'd1);
        end
      end
      begin
        logic [31:0] rd;
        int lt;
        for (int i = 0; i < 30; i++) begin
          logic [31:0] a;
          logic we;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          a  = 32'h4000 + 32'($urandom_range(128, 191)) * 4;
          we = 1'($urandom_range(0, 1));
          dma_op(we, a, $urandom, rd, lt);
          if (!we) chk("rnd_dma_data", rd, ref_mem[a[9:2]]);
          chk("rnd_dma_lat_bound", {31'h0, lt <= 8}, 32'd1);
        end
      end
    join

    repeat (4) @(posedge clk);
    #1;
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("final_mem", 32'(nbad), 32'd0);
    chk("pulse_count", 32'(n_pulses), 32'(exp_pulses));
    chk("pulse_width", 32'(pulse_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
